// File: rtl/qfix_pkg.sv
// rtl/qfix_pkg.sv - shared Q8.8 fixed-point constants and divider state type
package qfix_pkg;

    localparam int Q_WIDTH = 16;
    localparam int Q_FRAC  = 8;

    localparam logic [Q_WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [Q_WIDTH-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } qdiv_state_t;

endpackage

// File: rtl/qsat.sv
// rtl/qsat.sv - apply sign to an unsigned quotient magnitude and saturate to signed Q format
module qsat
    import qfix_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int FRAC  = Q_FRAC
) (
    input  logic [WIDTH+FRAC-1:0] mag,
    input  logic                  neg,
    output logic [WIDTH-1:0]      result,
    output logic                  ovf
);

    localparam int QW = WIDTH + FRAC;
    localparam logic [QW-1:0]    POS_LIM = QW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [QW-1:0]    NEG_LIM = QW'(64'd1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Negative side reaches one step further: -(2^(W-1)) is representable.
    always_comb begin
        result = mag[WIDTH-1:0];
        ovf    = 1'b0;
        if (neg) begin
            if (mag > NEG_LIM) begin
                result = SAT_MIN;
                ovf    = 1'b1;
            end else begin
                result = {WIDTH{1'b0}} - mag[WIDTH-1:0];
            end
        end else if (mag > POS_LIM) begin
            result = SAT_MAX;
            ovf    = 1'b1;
        end
    end

endmodule

// File: rtl/qdiv_seq.sv
// rtl/qdiv_seq.sv - sequential signed Q8.8 restoring divider with valid/ready handshake
module qdiv_seq
    import qfix_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int FRAC  = Q_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             dbz
);

    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    qdiv_state_t state, state_nx;

    logic [QW-1:0]    dq;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] b_abs;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH:0]   a_abs_in;
    logic [WIDTH-1:0] b_abs_in;
    logic [WIDTH:0]   rem_sh;
    logic             q_bit;
    logic [QW-1:0]    q_final;
    logic             last_step;
    logic             b_zero;
    logic [WIDTH-1:0] sat_result;
    logic             sat_ovf;

    // |a| needs one extra bit so the most negative dividend does not wrap.
    assign a_abs_in = a[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {a[WIDTH-1], a}) : {1'b0, a};
    assign b_abs_in = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
    assign b_zero   = (b == '0);

    assign rem_sh    = {rem, dq[QW-1]};
    assign q_bit     = (rem_sh >= {1'b0, b_abs});
    assign q_final   = {dq[QW-2:0], q_bit};
    assign last_step = (state == BUSY) && (cnt == CW'(QW - 1));

    qsat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_qsat (
        .mag    (q_final),
        .neg    (neg),
        .result (sat_result),
        .ovf    (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = b_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // dq holds the unconsumed dividend bits in its top and grows quotient bits from the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq        <= '0;
            rem       <= '0;
            b_abs     <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dq    <= QW'(a_abs_in) << FRAC;
                        rem   <= '0;
                        cnt   <= '0;
                        b_abs <= b_abs_in;
                        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                        if (b_zero) begin
                            dbz    <= 1'b1;
                            ovf    <= 1'b0;
                            result <= a[WIDTH-1] ? SAT_MIN : SAT_MAX;
                        end
                    end
                end
                BUSY: begin
                    dq  <= q_final;
                    rem <= WIDTH'(q_bit ? (rem_sh - {1'b0, b_abs}) : rem_sh);
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        result    <= sat_result;
                        ovf       <= sat_ovf;
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE with out_valid still low; raise it one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        ovf       <= 1'b0;
                        dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_seq.sv
// tb/tb_qdiv_seq.sv - directed self-checking bench for qdiv_seq
module tb_qdiv_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovf;
    logic        dbz;

    int total;
    int bad;

    qdiv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits 1 time unit after a rising edge; returns cycles from acceptance to out_valid.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        #3;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
        total++; if (ovf !== 1'b0 || dbz !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", ovf, dbz); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_divide();
        logic [15:0] va [10] = '{16'h0100, 16'hFE80, 16'h0040, 16'h0000, 16'h6400,
                                 16'h8000, 16'h8000, 16'h0300, 16'h7FFF, 16'h0100};
        logic [15:0] vb [10] = '{16'h0200, 16'h0080, 16'h00C0, 16'hFF00, 16'h0003,
                                 16'h0100, 16'hFF00, 16'hFF00, 16'h7FFF, 16'h8000};
        logic [15:0] vr [10] = '{16'h0080, 16'hFD00, 16'h0055, 16'h0000, 16'h7FFF,
                                 16'h8000, 16'h7FFF, 16'hFD00, 16'h0100, 16'hFFFE};
        logic        vo [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], lat);
            total++; if (lat !== 24) begin bad++; $display("FAIL div%0d_latency got=%0d want=24", i, lat); end
            total++; if (result !== vr[i]) begin bad++; $display("FAIL div%0d_result got=%h want=%h", i, result, vr[i]); end
            total++; if (ovf !== vo[i]) begin bad++; $display("FAIL div%0d_ovf got=%b want=%b", i, ovf, vo[i]); end
            total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div%0d_dbz got=%b want=0", i, dbz); end
            consume();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0) begin
                bad++; $display("FAIL div%0d_consume got=v%b r%b o%b want=v0 r1 o0", i, out_valid, in_ready, ovf);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [15:0] va [3] = '{16'hFF00, 16'h0000, 16'h0100};
        logic [15:0] vr [3] = '{16'h8000, 16'h7FFF, 16'h7FFF};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], 16'h0000, lat);
            total++; if (lat !== 1) begin bad++; $display("FAIL dbz%0d_latency got=%0d want=1", i, lat); end
            total++; if (result !== vr[i]) begin bad++; $display("FAIL dbz%0d_result got=%h want=%h", i, result, vr[i]); end
            total++; if (dbz !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL dbz%0d_flags got=d%b o%b want=d1 o0", i, dbz, ovf); end
            consume();
            total++; if (dbz !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL dbz%0d_clear got=d%b v%b want=d0 v0", i, dbz, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'h0100, 16'h0200, lat);
        total++; if (lat !== 24) begin bad++; $display("FAIL bp_latency got=%0d want=24", lat); end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                a = 16'h0400; b = 16'h0100; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0080 || ovf !== 1'b0 || dbz !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=v%b r%b res=%h want=v1 r0 res=0080", c, out_valid, in_ready, result);
            end
        end
        // in_valid held across the consuming edge must not be taken until IDLE.
        a = 16'h0400; b = 16'h0100; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=v%b r%b want=v0 r1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b want=0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 24 || result !== 16'h0400) begin
            bad++; $display("FAIL bp_next got=lat%0d res=%h want=lat24 res=0400", lat, result);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int accepts [2];
        int n;
        logic prev_ready;
        n          = 0;
        prev_ready = in_ready;
        a = 16'h0300; b = 16'h0100; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 80 && n < 2; i++) begin
            @(posedge clk); #1;
            if (prev_ready && !in_ready) begin
                accepts[n] = i;
                n++;
            end
            if (out_valid) begin
                total++; if (result !== 16'h0300) begin bad++; $display("FAIL b2b_result got=%h want=0300", result); end
            end
            prev_ready = in_ready;
        end
        in_valid = 1'b0;
        total++; if (n !== 2 || accepts[1] - accepts[0] !== 26) begin
            bad++; $display("FAIL b2b_interval got=n%0d gap%0d want=n2 gap26", n, accepts[1] - accepts[0]);
        end
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int lat;
        int stale;
        a = 16'h0100; b = 16'h0200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", in_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || ovf !== 1'b0 || dbz !== 1'b0) begin
            bad++; $display("FAIL rst_async got=r%b v%b res=%h o%b d%b want=r1 v0 res=0000 o0 d0", in_ready, out_valid, result, ovf, dbz);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL rst_stale got=%0d want=0", stale); end
        run_op(16'h0100, 16'h0200, lat);
        total++; if (lat !== 24 || result !== 16'h0080 || ovf !== 1'b0) begin
            bad++; $display("FAIL rst_recover got=lat%0d res=%h o%b want=lat24 res=0080 o0", lat, result, ovf);
        end
        consume();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_divide();
        test_div_by_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qdiv_seq.md
# qdiv_seq

Sequential signed Q8.8 divider computing `result = a / b` with a valid/ready handshake on both sides. It is the multi-cycle counterpart of the combinational Q8.8 arithmetic blocks (`qadd`). Typical uses are normalisation and average-pool scaling in the CNN datapath, where a single-cycle divider is too costly. It uses a restoring algorithm, one quotient bit per clock, and saturates to the Q8.8 range.

## Interface
Parameters:
- `WIDTH`, 16: total operand/result width (signed two's complement)
- `FRAC`, 8: fractional bits; the quotient has `WIDTH+FRAC` = 24 iterations

Ports:
- `clk`  input  1  single clock, rising-edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  operands `a`, `b` valid
- `in_ready`  output  1  block idle and able to accept operands
- `a`  input  16  signed Q8.8 dividend
- `b`  input  16  signed Q8.8 divisor
- `out_valid`  output  1  result valid; held until consumed
- `out_ready`  input  1  downstream accepts result
- `result`  output  16  signed Q8.8 quotient, truncated toward zero, saturated
- `ovf`  output  1  result saturated because of magnitude overflow
- `dbz`  output  1  divide by zero occurred

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, capture |a|<<FRAC (24-bit dividend), |b| (16-bit), and sign = a[15]^b[15]. Next state is BUSY, or DONE if b==0.
  - BUSY: one restoring step per cycle. Shift the partial remainder left, subtract |b|, and keep the difference if it is non-negative; the quotient bit is 1 when the difference is kept. A 5-bit counter counts steps 0..23. After step 23, the block applies the sign and saturation, registers the outputs, and goes to DONE.
  - DONE: `out_valid`=1. When `out_ready`=1, clear `out_valid`, `ovf` and `dbz`, and return to IDLE.
- Sign and saturation, using the 24-bit unsigned quotient magnitude `q`:
  - Positive result: if `q` > 32767, `result`=0x7FFF and `ovf`=1.
  - Negative result: if `q` > 32768, `result`=0x8000 and `ovf`=1. Otherwise `result` = −q, so exactly 0x8000 is representable without overflow.
- Divide by zero (b==0): `dbz`=1, `ovf`=0, and the block skips BUSY.
  - `result`=0x7FFF if a≥0 (including a==0).
  - `result`=0x8000 if a<0.
- |a| for a=0x8000 is 32768 and must be computed in 17 bits, not wrapped.
- Zero dividend with nonzero divisor yields 0x0000. The sign bit is ignored for a zero magnitude; −0 is never produced.
- `in_ready` is low in BUSY and DONE. A new operation cannot be accepted in the same cycle that a result is consumed.
- `in_valid` while not IDLE is ignored; operands are not buffered.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, `in_ready`=1, `out_valid`=0, `result`=0x0000, `ovf`=0, `dbz`=0, internal registers cleared.
- Reset asserted mid-operation aborts the operation immediately; no `out_valid` follows.
- Acceptance at edge N gives `out_valid`=1 after edge N+24, so latency is 24 cycles.
- Divide-by-zero acceptance at edge N gives `out_valid`=1 after edge N+1.
- `result`, `ovf` and `dbz` are stable while `out_valid`=1 and `out_ready`=0, for any number of cycles.
- `in_ready` rises after the consuming edge. Minimum initiation interval is 26 cycles for nonzero divisors.

## Structure
- Shared package `qfix_pkg`, to be reused by `qadd` and future Q blocks:
  - `Q_WIDTH`=16, `Q_FRAC`=8
  - `Q_MAX`=16'h7FFF, `Q_MIN`=16'h8000
  - state enum `qdiv_state_t` {IDLE, BUSY, DONE}
- One natural sub-module, `qsat`: a combinational sign-apply and saturate function from a 24-bit magnitude plus sign to 16-bit Q8.8 and `ovf`.
- The divider datapath and FSM stay in `qdiv_seq`.

## Test plan
- a=0x0100 (1.0), b=0x0200 (2.0) → `result`=0x0080, `ovf`=0, `dbz`=0, `out_valid` exactly 24 cycles after acceptance.
- a=0xFE80 (−1.5), b=0x0080 (0.5) → 0xFD00 (−3.0). a=0x0040 (0.25), b=0x00C0 (0.75) → 0x0055 (truncated). a=0x0000, b=0xFF00 → 0x0000.
- a=0x6400 (100.0), b=0x0003 → 0x7FFF, `ovf`=1. a=0x8000, b=0x0100 → 0x8000, `ovf`=0. a=0x8000, b=0xFF00 → 0x7FFF, `ovf`=1.
- a=0xFF00, b=0x0000 → 0x8000, `dbz`=1, `out_valid` 1 cycle after acceptance. a=0x0000, b=0x0000 → 0x7FFF, `dbz`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → outputs stable, `in_ready`=0, and a pulsed `in_valid` is ignored. Release → next operation is accepted only after return to IDLE.
- Drop `rst_n` at BUSY step 10 → all outputs at reset values immediately. After release, a new operation 1.0/2.0 completes correctly with no stale result.
